// File: rtl/bank_pkg.sv
// Shared types and sizing for the bank linefill buffer.
package bank_pkg;

  localparam int unsigned LFB_ID_W   = 6;
  localparam int unsigned LFB_BEAT_W = 64;
  localparam int unsigned LFB_LINE_W = 256;
  localparam int unsigned LFB_BEATS  = LFB_LINE_W / LFB_BEAT_W;
  localparam int unsigned LFB_SLOTS  = 1 << LFB_ID_W;
  localparam int unsigned LFB_CNT_W  = (LFB_BEATS > 1) ? $clog2(LFB_BEATS) : 1;
  localparam int unsigned LFB_PCNT_W = LFB_ID_W + 1;
  localparam int unsigned LFB_LSB_W  = $clog2(LFB_LINE_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FILL = 2'd2,
    FULL = 2'd3
  } lfb_state_e;

endpackage

// File: rtl/bank_linefill_buffer_if.sv
// Bus bundle between the linefill buffer, the BIU read channel and the bank issue queue.
interface bank_linefill_buffer_if;
  import bank_pkg::*;

  logic                  alloc_valid_i;
  logic [LFB_ID_W-1:0]   alloc_id_i;
  logic                  biu_rvalid_i;
  logic                  biu_rready_o;
  logic [LFB_ID_W-1:0]   biu_rid_i;
  logic [LFB_BEAT_W-1:0] biu_rdata_i;
  logic                  biu_rlast_i;
  logic                  lfb_isu_rvalid_o;
  logic [LFB_ID_W-1:0]   lfb_isu_rid_o;
  logic [LFB_ID_W-1:0]   lfb_raddr_i;
  logic [LFB_LINE_W-1:0] lfb_rdata_o;
  logic                  free_valid_i;
  logic [LFB_ID_W-1:0]   free_id_i;
  logic [LFB_PCNT_W-1:0] lfb_pend_cnt_o;
  logic                  lfb_err_o;

  modport slave (
    input  alloc_valid_i, alloc_id_i, biu_rvalid_i, biu_rid_i, biu_rdata_i, biu_rlast_i,
           lfb_raddr_i, free_valid_i, free_id_i,
    output biu_rready_o, lfb_isu_rvalid_o, lfb_isu_rid_o, lfb_rdata_o, lfb_pend_cnt_o, lfb_err_o
  );

  modport master (
    output alloc_valid_i, alloc_id_i, biu_rvalid_i, biu_rid_i, biu_rdata_i, biu_rlast_i,
           lfb_raddr_i, free_valid_i, free_id_i,
    input  biu_rready_o, lfb_isu_rvalid_o, lfb_isu_rid_o, lfb_rdata_o, lfb_pend_cnt_o, lfb_err_o
  );

endinterface

// File: rtl/bank_lfb_slot.sv
// One linefill slot: lifecycle state and beat counter.
module bank_lfb_slot
  import bank_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_alloc,
  input  logic                 i_free,
  input  logic                 i_beat,
  output lfb_state_e           o_state,
  output logic [LFB_CNT_W-1:0] o_cnt,
  output logic                 o_alloc_ok_c,
  output logic                 o_free_ok_c,
  output logic                 o_wr_en_c,
  output logic                 o_done_c
);

  localparam logic [LFB_CNT_W-1:0] LAST_CNT = LFB_CNT_W'(LFB_BEATS - 1);

  lfb_state_e           r_state;
  lfb_state_e           w_state_n;
  logic [LFB_CNT_W-1:0] r_cnt;
  logic [LFB_CNT_W-1:0] w_cnt_n;

  // State and beat counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Next state: beats only land in PEND/FILL; a FULL slot freed and re-allocated together goes straight to PEND.
  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    o_alloc_ok_c = 1'b0;
    o_free_ok_c  = 1'b0;
    o_wr_en_c    = 1'b0;
    o_done_c     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_alloc) begin
          w_state_n    = PEND;
          o_alloc_ok_c = 1'b1;
        end
      end
      PEND, FILL: begin
        if (i_beat) begin
          o_wr_en_c = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_state_n = FULL;
            w_cnt_n   = '0;
            o_done_c  = 1'b1;
          end else begin
            w_state_n = FILL;
            w_cnt_n   = LFB_CNT_W'(r_cnt + 1'b1);
          end
        end
      end
      FULL: begin
        if (i_free) begin
          o_free_ok_c = 1'b1;
          if (i_alloc) begin
            w_state_n    = PEND;
            o_alloc_ok_c = 1'b1;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign o_state = r_state;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/bank_linefill_buffer.sv
// Bank linefill buffer: gathers BIU beats into per-ID line slots and hands complete lines to the issue queue.
// Optional protocol checking is enabled by defining LFB_BEAT_CHECK_EN.
module bank_linefill_buffer
  import bank_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  bank_linefill_buffer_if.slave  bus
);

  logic                                r_rready;
  logic                                r_isu_rvalid;
  logic [LFB_ID_W-1:0]                 r_isu_rid;
  logic [LFB_PCNT_W-1:0]               r_pend_cnt;
  logic [LFB_LINE_W-1:0]               r_data [LFB_SLOTS];

  logic                                w_beat_acc;
  logic [LFB_SLOTS-1:0]                w_alloc_ok;
  logic [LFB_SLOTS-1:0]                w_free_ok;
  logic [LFB_SLOTS-1:0]                w_wr_en;
  logic [LFB_SLOTS-1:0]                w_done;
  logic [LFB_SLOTS-1:0][LFB_CNT_W-1:0] w_cnt;
  lfb_state_e [LFB_SLOTS-1:0]          w_state;
  logic                                w_alloc_any;
  logic                                w_free_any;
  logic [LFB_LSB_W-1:0]                w_wr_lsb;

  assign w_beat_acc  = bus.biu_rvalid_i & r_rready;
  assign w_alloc_any = |w_alloc_ok;
  assign w_free_any  = |w_free_ok;
  assign w_wr_lsb    = LFB_LSB_W'(LFB_BEAT_W) * LFB_LSB_W'(w_cnt[bus.biu_rid_i]);

  for (genvar g = 0; g < LFB_SLOTS; g++) begin : g_slot
    bank_lfb_slot u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .i_alloc      (bus.alloc_valid_i && (bus.alloc_id_i == LFB_ID_W'(g))),
      .i_free       (bus.free_valid_i && (bus.free_id_i == LFB_ID_W'(g))),
      .i_beat       (w_beat_acc && (bus.biu_rid_i == LFB_ID_W'(g))),
      .o_state      (w_state[g]),
      .o_cnt        (w_cnt[g]),
      .o_alloc_ok_c (w_alloc_ok[g]),
      .o_free_ok_c  (w_free_ok[g]),
      .o_wr_en_c    (w_wr_en[g]),
      .o_done_c     (w_done[g])
    );
  end

  // Line storage: one beat lane per cycle, not reset.
  always_ff @(posedge clk_i) begin
    if (|w_wr_en) begin
      r_data[bus.biu_rid_i][w_wr_lsb +: LFB_BEAT_W] <= bus.biu_rdata_i;
    end
  end

  // Ready, completion pulse and outstanding-slot count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rready     <= 1'b0;
      r_isu_rvalid <= 1'b0;
      r_isu_rid    <= '0;
      r_pend_cnt   <= '0;
    end else begin
      r_rready     <= 1'b1;
      r_isu_rvalid <= |w_done;
      if (|w_done) begin
        r_isu_rid <= bus.biu_rid_i;
      end
      case ({w_alloc_any, w_free_any})
        2'b10:   r_pend_cnt <= LFB_PCNT_W'(r_pend_cnt + 1'b1);
        2'b01:   r_pend_cnt <= LFB_PCNT_W'(r_pend_cnt - 1'b1);
        default: r_pend_cnt <= r_pend_cnt;
      endcase
    end
  end

`ifdef LFB_BEAT_CHECK_EN
  logic       r_err;
  lfb_state_e w_rid_state;
  logic       w_rid_open;
  logic       w_rid_last;
  logic       w_err_set;

  assign w_rid_state = w_state[bus.biu_rid_i];
  assign w_rid_open  = (w_rid_state == PEND) || (w_rid_state == FILL);
  assign w_rid_last  = (w_cnt[bus.biu_rid_i] == LFB_CNT_W'(LFB_BEATS - 1));
  assign w_err_set   = (w_beat_acc && (!w_rid_open || (bus.biu_rlast_i != w_rid_last)))
                     || (bus.alloc_valid_i && !w_alloc_any)
                     || (bus.free_valid_i && !w_free_any);

  // Sticky protocol error; completion itself never depends on rlast.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign bus.lfb_err_o = r_err;
`else
  logic w_unused_chk;
  assign w_unused_chk  = ^{bus.biu_rlast_i, w_state};
  assign bus.lfb_err_o = 1'b0;
`endif

  assign bus.biu_rready_o     = r_rready;
  assign bus.lfb_isu_rvalid_o = r_isu_rvalid;
  assign bus.lfb_isu_rid_o    = r_isu_rid;
  assign bus.lfb_pend_cnt_o   = r_pend_cnt;
  assign bus.lfb_rdata_o      = r_data[bus.lfb_raddr_i];

endmodule

// File: tb/tb_bank_linefill_buffer.sv
// Self-checking bench for bank_linefill_buffer: directed table, hand sequences, randomized run vs. slot model.
module tb_bank_linefill_buffer;
  import bank_pkg::*;

`ifdef LFB_BEAT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk_i;
  logic rst_i;
  int   checks;
  int   errors;

  bank_linefill_buffer_if bus();

  bank_linefill_buffer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: 0 free, 1 awaiting/collecting beats, 2 holding a complete line.
  int                    m_st    [LFB_SLOTS];
  int                    m_nb    [LFB_SLOTS];
  logic [LFB_LINE_W-1:0] m_line  [LFB_SLOTS];
  bit   [LFB_BEATS-1:0]  m_known [LFB_SLOTS];
  bit                    m_rready;
  bit                    m_pulse;
  int                    m_rid;
  bit                    m_err;

  typedef struct {
    bit                    av;
    int                    aid;
    bit                    rv;
    int                    rid;
    logic [LFB_BEAT_W-1:0] rd;
    bit                    rl;
    bit                    fv;
    int                    fid;
    int                    raddr;
    bit                    ep;
    int                    erid;
    int                    epend;
    bit                    cl;
    logic [LFB_LINE_W-1:0] eline;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [LFB_BEAT_W-1:0] bd(input int tag, input int k);
    return {8'(tag), 8'(k), 48'h0123_4567_89AB};
  endfunction

  function automatic logic [LFB_LINE_W-1:0] line4(input int tag);
    return {bd(tag, 3), bd(tag, 2), bd(tag, 1), bd(tag, 0)};
  endfunction

  function automatic vec_t mk(input bit av, input int aid, input bit rv, input int rid,
                              input logic [LFB_BEAT_W-1:0] rd, input bit rl, input bit fv,
                              input int fid, input int raddr, input bit ep, input int erid,
                              input int epend, input bit cl, input logic [LFB_LINE_W-1:0] eline);
    vec_t v;
    v.av = av; v.aid = aid; v.rv = rv; v.rid = rid; v.rd = rd; v.rl = rl;
    v.fv = fv; v.fid = fid; v.raddr = raddr; v.ep = ep; v.erid = erid;
    v.epend = epend; v.cl = cl; v.eline = eline;
    return v;
  endfunction

  function automatic vec_t r_alloc(input int id, input int erid, input int epend);
    return mk(1, id, 0, 0, '0, 0, 0, 0, 0, 0, erid, epend, 0, '0);
  endfunction

  function automatic vec_t r_free(input int id, input int erid, input int epend);
    return mk(0, 0, 0, 0, '0, 0, 1, id, 0, 0, erid, epend, 0, '0);
  endfunction

  function automatic vec_t r_af(input int id, input int erid, input int epend);
    return mk(1, id, 0, 0, '0, 0, 1, id, 0, 0, erid, epend, 0, '0);
  endfunction

  function automatic vec_t r_beat(input int id, input logic [LFB_BEAT_W-1:0] d, input bit l,
                                  input bit ep, input int erid, input int epend);
    return mk(0, 0, 1, id, d, l, 0, 0, 0, ep, erid, epend, 0, '0);
  endfunction

  function automatic vec_t r_ab(input int id, input logic [LFB_BEAT_W-1:0] d, input int erid,
                                input int epend);
    return mk(1, id, 1, id, d, 0, 0, 0, 0, 0, erid, epend, 0, '0);
  endfunction

  function automatic vec_t r_look(input int raddr, input int erid, input int epend,
                                  input logic [LFB_LINE_W-1:0] eline);
    return mk(0, 0, 0, 0, '0, 0, 0, 0, raddr, 0, erid, epend, 1, eline);
  endfunction

  task automatic chk(input string nm, input logic [LFB_LINE_W-1:0] act,
                     input logic [LFB_LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input bit av, input int aid, input bit rv, input int rid,
                        input logic [LFB_BEAT_W-1:0] rd, input bit rl, input bit fv,
                        input int fid, input int raddr);
    bus.alloc_valid_i = av;
    bus.alloc_id_i    = LFB_ID_W'(aid);
    bus.biu_rvalid_i  = rv;
    bus.biu_rid_i     = LFB_ID_W'(rid);
    bus.biu_rdata_i   = rd;
    bus.biu_rlast_i   = rl;
    bus.free_valid_i  = fv;
    bus.free_id_i     = LFB_ID_W'(fid);
    bus.lfb_raddr_i   = LFB_ID_W'(raddr);
  endtask

  task automatic set_idle();
    set_in(0, 0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  function automatic int m_pend();
    int n = 0;
    for (int i = 0; i < LFB_SLOTS; i++) if (m_st[i] != 0) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LFB_SLOTS; i++) begin
      m_st[i] = 0;
      m_nb[i] = 0;
    end
    m_rready = 0;
    m_pulse  = 0;
    m_rid    = 0;
    m_err    = 0;
  endfunction

  // Applies one clock edge of the slot rules to the model, using pre-edge slot states throughout.
  function automatic void model_step();
    int pre [LFB_SLOTS];
    int r, a, f;
    bit done;
    pre  = m_st;
    done = 0;
    r = int'(bus.biu_rid_i);
    a = int'(bus.alloc_id_i);
    f = int'(bus.free_id_i);
    if (m_rready && bus.biu_rvalid_i) begin
      if (pre[r] == 1) begin
        m_line[r][LFB_BEAT_W*m_nb[r] +: LFB_BEAT_W] = bus.biu_rdata_i;
        m_known[r][m_nb[r]] = 1'b1;
        m_nb[r]++;
        if (m_nb[r] == LFB_BEATS) begin
          m_st[r] = 2;
          m_nb[r] = 0;
          done    = 1;
        end
        if (CHK_EN && (bus.biu_rlast_i != done)) m_err = 1;
      end else if (CHK_EN) begin
        m_err = 1;
      end
    end
    if (bus.free_valid_i) begin
      if (pre[f] == 2) m_st[f] = 0;
      else if (CHK_EN) m_err = 1;
    end
    if (bus.alloc_valid_i) begin
      if (pre[a] == 0 || (pre[a] == 2 && bus.free_valid_i && f == a)) m_st[a] = 1;
      else if (CHK_EN) m_err = 1;
    end
    m_pulse = done;
    if (done) m_rid = r;
    m_rready = 1;
  endfunction

  task automatic model_check();
    int ra;
    ra = int'(bus.lfb_raddr_i);
    chk("rready", 256'(bus.biu_rready_o), 256'(m_rready));
    chk("pulse", 256'(bus.lfb_isu_rvalid_o), 256'(m_pulse));
    chk("rid", 256'(bus.lfb_isu_rid_o), 256'(m_rid));
    chk("pend", 256'(bus.lfb_pend_cnt_o), 256'(m_pend()));
    chk("err", 256'(bus.lfb_err_o), 256'(m_err));
    if (&m_known[ra]) chk("rdata", bus.lfb_rdata_o, m_line[ra]);
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    model_check();
  endtask

  task automatic do_reset();
    set_idle();
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    model_check();
    rst_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < LFB_SLOTS; i++) m_known[i] = '0;
    rst_i = 1'b1;
    set_idle();
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_rready", 256'(bus.biu_rready_o), 256'(0));
    chk("rst_pulse", 256'(bus.lfb_isu_rvalid_o), 256'(0));
    chk("rst_rid", 256'(bus.lfb_isu_rid_o), 256'(0));
    chk("rst_pend", 256'(bus.lfb_pend_cnt_o), 256'(0));
    chk("rst_err", 256'(bus.lfb_err_o), 256'(0));
    rst_i = 1'b0;

    // Directed cycle table: {inputs, expected pulse/rid/pend/line}.
    vecs.push_back(r_alloc(5, 0, 1));
    for (int k = 0; k < 4; k++) vecs.push_back(r_beat(5, bd('hA, k), k == 3, k == 3, (k == 3) ? 5 : 0, 1));
    vecs.push_back(r_look(5, 5, 1, line4('hA)));
    vecs.push_back(r_free(5, 5, 0));
    for (int k = 0; k < 4; k++) vecs.push_back(r_beat(5, bd('h55, k), k == 3, 0, 5, 0));
    vecs.push_back(r_alloc(1, 5, 1));
    vecs.push_back(r_alloc(2, 5, 2));
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(r_beat(1, bd('hB, k), k == 3, k == 3, (k == 3) ? 1 : 5, 2));
      vecs.push_back(r_beat(2, bd('hC, k), k == 3, k == 3, (k == 3) ? 2 : 5, 2));
    end
    vecs.push_back(r_look(1, 2, 2, line4('hB)));
    vecs.push_back(r_look(2, 2, 2, line4('hC)));
    vecs.push_back(r_alloc(7, 2, 3));
    for (int k = 0; k < 4; k++) vecs.push_back(r_beat(7, bd('hD, k), k == 3, k == 3, (k == 3) ? 7 : 2, 3));
    vecs.push_back(r_af(7, 7, 3));
    for (int k = 0; k < 4; k++) vecs.push_back(r_beat(7, bd('hE, k), k == 3, k == 3, 7, 3));
    vecs.push_back(r_look(7, 7, 3, line4('hE)));
    vecs.push_back(r_ab(9, bd('h99, 9), 7, 4));
    for (int k = 0; k < 4; k++) vecs.push_back(r_beat(9, bd('hF, k), k == 3, k == 3, (k == 3) ? 9 : 7, 4));
    vecs.push_back(r_look(9, 9, 4, line4('hF)));
    vecs.push_back(r_free(3, 9, 4));
    vecs.push_back(r_alloc(7, 9, 4));
    vecs.push_back(r_free(7, 9, 3));
    vecs.push_back(r_free(1, 9, 2));
    vecs.push_back(r_free(2, 9, 1));
    vecs.push_back(r_free(9, 9, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].av, vecs[i].aid, vecs[i].rv, vecs[i].rid, vecs[i].rd, vecs[i].rl,
             vecs[i].fv, vecs[i].fid, vecs[i].raddr);
      step();
      chk($sformatf("tbl%0d_pulse", i), 256'(bus.lfb_isu_rvalid_o), 256'(vecs[i].ep));
      chk($sformatf("tbl%0d_rid", i), 256'(bus.lfb_isu_rid_o), 256'(vecs[i].erid));
      chk($sformatf("tbl%0d_pend", i), 256'(bus.lfb_pend_cnt_o), 256'(vecs[i].epend));
      if (vecs[i].cl) chk($sformatf("tbl%0d_line", i), bus.lfb_rdata_o, vecs[i].eline);
    end

    // Reset in the middle of a burst to slot 3.
    set_in(1, 3, 0, 0, '0, 0, 0, 0, 3);
    step();
    for (int k = 0; k < 2; k++) begin
      set_in(0, 0, 1, 3, bd('h33, k), 0, 0, 0, 3);
      step();
    end
    set_idle();
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_pend", 256'(bus.lfb_pend_cnt_o), 256'(0));
    chk("mid_rst_rready", 256'(bus.biu_rready_o), 256'(0));
    chk("mid_rst_pulse", 256'(bus.lfb_isu_rvalid_o), 256'(0));
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    for (int k = 2; k < 4; k++) begin
      set_in(0, 0, 1, 3, bd('h33, k), k == 3, 0, 0, 3);
      step();
      chk("post_rst_pulse", 256'(bus.lfb_isu_rvalid_o), 256'(0));
      chk("post_rst_pend", 256'(bus.lfb_pend_cnt_o), 256'(0));
    end
    set_idle();
    step();
    chk("post_rst_idle_pulse", 256'(bus.lfb_isu_rvalid_o), 256'(0));

    // Early rlast: flagged when checking is built in, completion still waits for the 4th beat.
    do_reset();
    set_in(1, 4, 0, 0, '0, 0, 0, 0, 4);
    step();
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, 4, bd('h44, k), (k == 1) || (k == 3), 0, 0, 4);
      step();
      chk($sformatf("rlast_b%0d_err", k), 256'(bus.lfb_err_o), 256'((k >= 1) ? CHK_EN : 1'b0));
      chk($sformatf("rlast_b%0d_pulse", k), 256'(bus.lfb_isu_rvalid_o), 256'(k == 3));
    end
    chk("rlast_rid", 256'(bus.lfb_isu_rid_o), 256'(4));
    set_in(0, 0, 0, 0, '0, 0, 1, 4, 4);
    step();
    chk("rlast_line", bus.lfb_rdata_o, line4('h44));
    chk("rlast_err_sticky", 256'(bus.lfb_err_o), 256'(CHK_EN));

    // Randomized traffic on a few IDs so collisions are frequent.
    for (int c = 0; c < 1500; c++) begin
      int rid;
      bit fin;
      bit rl;
      rid = int'($urandom_range(0, 7));
      fin = (m_st[rid] == 1) && (m_nb[rid] == LFB_BEATS - 1);
      rl  = ($urandom_range(0, 99) < 90) ? fin : !fin;
      set_in($urandom_range(0, 99) < 25, int'($urandom_range(0, 7)),
             $urandom_range(0, 99) < 65, rid, {$urandom, $urandom}, rl,
             $urandom_range(0, 99) < 25, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      step();
    end
    set_idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
